// File: rtl/axilwr2wbsp.sv
// AXI-lite write channel to pipelined Wishbone bridge: joins one AW and one W beat
// into a single WB write and reports the ack/err (or watchdog abort) on the B channel.
module axilwr2wbsp #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGTIMEOUT        = 10,
  localparam int DW = C_AXI_DATA_WIDTH,
  localparam int AW = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH / 8)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_axi_awvalid,
  output logic            o_axi_awready,
  input  logic [AW-1:0]   i_axi_awaddr,
  input  logic [2:0]      i_axi_awprot,
  input  logic            i_axi_wvalid,
  output logic            o_axi_wready,
  input  logic [DW-1:0]   i_axi_wdata,
  input  logic [DW/8-1:0] i_axi_wstrb,
  output logic            o_axi_bvalid,
  input  logic            i_axi_bready,
  output logic [1:0]      o_axi_bresp,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_STB, S_WAIT, S_RESP} state_t;

  // Last count value before the watchdog fires; cyc is then high 2^LGTIMEOUT-1 cycles.
  localparam logic [LGTIMEOUT-1:0] TLAST = LGTIMEOUT'((1 << LGTIMEOUT) - 2);

  state_t               state_q, state_d;
  logic                 aw_full_q, aw_full_d;
  logic                 w_full_q, w_full_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [LGTIMEOUT-1:0] timer_q, timer_d;
  logic [AW-1:0]        awaddr_q, addr_q;
  logic [DW-1:0]        wdata_q, data_q;
  logic [DW/8-1:0]      wstrb_q, sel_q;
  logic                 launch;
  logic                 unused_ok;

  assign unused_ok = ^i_axi_awprot;
  assign launch    = (state_q == S_IDLE) && aw_full_q && w_full_q;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    timer_d   = timer_q;
    // A launch only happens with both buffers full, so it never races a handshake.
    aw_full_d = launch ? 1'b0 : (aw_full_q || i_axi_awvalid);
    w_full_d  = launch ? 1'b0 : (w_full_q || i_axi_wvalid);
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_STB;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          timer_d = '0;
        end
      end
      S_STB, S_WAIT: begin
        if (i_wb_ack || i_wb_err) begin
          state_d  = S_RESP;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = i_wb_err ? 2'b10 : 2'b00;
        end else if (timer_q == TLAST) begin
          state_d  = S_RESP;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = 2'b10;
        end else begin
          timer_d = timer_q + 1'b1;
          if ((state_q == S_STB) && !i_wb_stall) begin
            state_d = S_WAIT;
            stb_d   = 1'b0;
          end
        end
      end
      S_RESP: begin
        if (i_axi_bready) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      timer_q   <= timer_d;
    end
  end

  // Datapath registers carry no reset; they are only observed while qualified.
  always_ff @(posedge i_clk) begin
    if (i_axi_awvalid && !aw_full_q) awaddr_q <= i_axi_awaddr;
    if (i_axi_wvalid && !w_full_q) begin
      wdata_q <= i_axi_wdata;
      wstrb_q <= i_axi_wstrb;
    end
    if (launch) begin
      addr_q <= awaddr_q;
      data_q <= wdata_q;
      sel_q  <= wstrb_q;
    end
  end

  assign o_axi_awready = !aw_full_q;
  assign o_axi_wready  = !w_full_q;
  assign o_axi_bvalid  = bvalid_q;
  assign o_axi_bresp   = bresp_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = cyc_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = data_q;
  assign o_wb_sel      = sel_q;

endmodule

// File: tb/tb_axilwr2wbsp.sv
// Bench for axilwr2wbsp: transaction-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized AXI/WB traffic.
module tb_axilwr2wbsp;
  localparam int DW   = 32;
  localparam int AW   = 26;
  localparam int LGT  = 4;
  localparam int TMAX = (1 << LGT) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp;
  logic            cyc, stb, we, stall, ack, err;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [DW/8-1:0] wb_sel;

  always #5 clk = ~clk;

  axilwr2wbsp #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(28), .LGTIMEOUT(LGT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr),
    .i_axi_awprot(awprot),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_data), .o_wb_sel(wb_sel),
    .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered beats as queues, one outstanding write as a few flags.
  logic [AW-1:0]      m_awq[$];
  logic [DW+DW/8-1:0] m_wq[$];
  bit                 m_cyc = 0, m_stb = 0, m_bvalid = 0;
  logic [1:0]         m_bresp = 2'b00;
  int                 m_t = 0;
  logic [AW-1:0]      m_addr = '0;
  logic [DW-1:0]      m_data = '0;
  logic [DW/8-1:0]    m_sel = '0;
  bit                 aw_took = 0, w_took = 0;

  always @(posedge clk) begin
    bit aw_hs, w_hs;
    if (rst) begin
      m_awq.delete(); m_wq.delete();
      m_cyc = 0; m_stb = 0; m_bvalid = 0; m_bresp = 2'b00;
      aw_took = 0; w_took = 0;
    end else begin
      aw_hs = awvalid && (m_awq.size() == 0);
      w_hs  = wvalid && (m_wq.size() == 0);
      aw_took = aw_hs;
      w_took  = w_hs;
      if (!m_cyc && !m_bvalid) begin
        if (m_awq.size() > 0 && m_wq.size() > 0) begin
          m_addr = m_awq.pop_front();
          {m_data, m_sel} = m_wq.pop_front();
          m_cyc = 1; m_stb = 1; m_t = 0;
        end
      end else if (m_cyc) begin
        if (ack || err) begin
          m_cyc = 0; m_stb = 0; m_bvalid = 1; m_bresp = err ? 2'b10 : 2'b00;
        end else if (m_t + 1 == TMAX) begin
          m_cyc = 0; m_stb = 0; m_bvalid = 1; m_bresp = 2'b10;
        end else begin
          m_t++;
          m_stb = m_stb && stall;
        end
      end else if (bready) begin
        m_bvalid = 0;
      end
      if (aw_hs) m_awq.push_back(awaddr);
      if (w_hs)  m_wq.push_back({wdata, wstrb});
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("awready", 64'(awready), 64'(m_awq.size() == 0));
      check("wready",  64'(wready),  64'(m_wq.size() == 0));
      check("cyc",     64'(cyc),     64'(m_cyc));
      check("stb",     64'(stb),     64'(m_stb));
      check("we",      64'(we),      64'(m_cyc));
      check("bvalid",  64'(bvalid),  64'(m_bvalid));
      check("bresp",   64'(bresp),   64'(m_bresp));
      if (m_stb) begin
        check("wb_addr", 64'(wb_addr), 64'(m_addr));
        check("wb_data", 64'(wb_data), 64'(m_data));
        check("wb_sel",  64'(wb_sel),  64'(m_sel));
      end
    end
  end

  // Observed event counters for literal checks.
  int   cyc_rises = 0, b_hs = 0;
  logic prev_cyc = 1'b0;
  always @(negedge clk) begin
    if (cyc && !prev_cyc) cyc_rises++;
    if (bvalid && bready) b_hs++;
    prev_cyc = cyc;
  end

  // Slave modes: 0 ack after accept, 1 err after accept, 2 hang, 3 stall then ack, 4 random, 5 manual
  int  smode = 0, stall_left = 0;
  bit  rand_axi = 0;

  task automatic drive();
    int r;
    case (smode)
      0: begin stall = 0; ack = m_cyc && !m_stb; err = 0; end
      1: begin stall = 0; ack = 0; err = m_cyc && !m_stb; end
      2: begin stall = 0; ack = 0; err = 0; end
      3: begin
        stall = m_stb && (stall_left > 0);
        if (m_stb && stall_left > 0) stall_left--;
        ack = m_cyc && !m_stb; err = 0;
      end
      4: begin
        stall = m_stb && ($urandom % 3 == 0);
        r = int'($urandom % 8);
        if (m_cyc) begin ack = (r < 2) || (r == 3); err = (r == 2) || (r == 3); end
        else begin ack = ($urandom % 10 == 0); err = 0; end
      end
      default: ;
    endcase
    if (rand_axi) begin
      if (!awvalid || aw_took) begin awvalid = ($urandom % 3) != 0; awaddr = AW'($urandom); end
      if (!wvalid || w_took) begin
        wvalid = ($urandom % 3) != 0; wdata = $urandom; wstrb = 4'($urandom);
      end
      bready = ($urandom % 4) != 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    step();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n;
    n = 0;
    r = 2'b11;
    while (!bvalid && n < 60) begin step(); n++; end
    if (!bvalid) begin
      n_tests++; n_fail++;
      $display("FAIL bvalid_timeout: bvalid never rose, required within 60 cycles");
    end else r = bresp;
  endtask

  initial begin
    logic [1:0] r;
    int c0, n, bh0;
    rst = 1; awvalid = 0; awaddr = '0; awprot = 3'b0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 1; stall = 0; ack = 0; err = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'(1));
    check("rst_wready",  64'(wready),  64'(1));
    check("rst_bvalid",  64'(bvalid),  64'(0));
    check("rst_bresp",   64'(bresp),   64'(0));
    check("rst_cyc",     64'(cyc),     64'(0));
    check("rst_stb",     64'(stb),     64'(0));
    check("rst_we",      64'(we),      64'(0));
    rst = 0;
    chk_en = 1;

    // Single write, AW and W together, zero-stall slave
    smode = 0;
    do_write(AW'(32'h10), 32'hDEADBEEF, 4'hF);
    check("t1_awready_k", 64'(awready), 64'(0));
    step();
    check("t1_stb_k1",  64'(stb), 64'(1));
    check("t1_addr",    64'(wb_addr), 64'(32'h10));
    check("t1_data",    64'(wb_data), 64'(32'hDEADBEEF));
    check("t1_sel",     64'(wb_sel), 64'(4'hF));
    check("t1_awready_k1", 64'(awready), 64'(1));
    step();
    check("t1_stb_k2",  64'(stb), 64'(0));
    check("t1_cyc_k2",  64'(cyc), 64'(1));
    step();
    check("t1_bvalid_k3", 64'(bvalid), 64'(1));
    check("t1_bresp",     64'(bresp), 64'(0));
    step();
    check("t1_bvalid_k4", 64'(bvalid), 64'(0));

    // W five cycles ahead of AW, slave stalls four cycles
    smode = 3; stall_left = 4;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'h3;
    step(); wvalid = 0;
    repeat (4) step();
    awvalid = 1; awaddr = AW'(32'h20);
    step(); awvalid = 0;
    n = 0; bh0 = b_hs;
    for (int i = 0; i < 20; i++) begin step(); if (stb) n++; end
    check("t2_stb_cycles", 64'(n), 64'(5));
    check("t2_b_count", 64'(b_hs - bh0), 64'(1));

    // Error response, then a normal write
    smode = 1; c0 = cyc_rises;
    do_write(AW'(32'h30), 32'hCAFEF00D, 4'hC);
    wait_b(r);
    check("t3_err_bresp", 64'(r), 64'(2'b10));
    step();
    smode = 0;
    do_write(AW'(32'h34), 32'h0BADF00D, 4'h0);
    wait_b(r);
    check("t3_ok_bresp", 64'(r), 64'(2'b00));
    step();
    check("t3_wb_cycles", 64'(cyc_rises - c0), 64'(2));

    // Watchdog: slave never responds
    smode = 2; bready = 0;
    do_write(AW'(32'h40), 32'h55AA55AA, 4'hF);
    n = 0;
    for (int i = 0; i < 40; i++) begin step(); if (cyc) n++; end
    check("t4_cyc_cycles", 64'(n), 64'(TMAX));
    check("t4_bvalid", 64'(bvalid), 64'(1));
    check("t4_bresp",  64'(bresp), 64'(2'b10));
    smode = 5; ack = 1;
    repeat (3) step();
    check("t4_late_ack_cyc", 64'(cyc), 64'(0));
    ack = 0; bready = 1;
    step();
    bh0 = b_hs; ack = 1;
    repeat (4) step();
    ack = 0;
    check("t4_no_second_b", 64'(b_hs - bh0), 64'(0));

    // bready low while further pairs arrive
    smode = 0; bready = 0;
    do_write(AW'(32'h100), 32'h1, 4'h1);
    wait_b(r);
    awvalid = 1; awaddr = AW'(32'h200); wvalid = 1; wdata = 32'h2; wstrb = 4'h2;
    step();
    awaddr = AW'(32'h300); wdata = 32'h3; wstrb = 4'h4;
    step();
    check("t5_awready_full", 64'(awready), 64'(0));
    check("t5_wready_full",  64'(wready),  64'(0));
    c0 = cyc_rises;
    repeat (8) step();
    check("t5_no_cycle", 64'(cyc_rises - c0), 64'(0));
    bready = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (aw_took) awvalid = 0;
      if (w_took) wvalid = 0;
    end
    check("t5_two_cycles", 64'(cyc_rises - c0), 64'(2));

    // Reset while stb is stalled
    smode = 3; stall_left = 100;
    do_write(AW'(32'h500), 32'h77777777, 4'hF);
    repeat (4) step();
    check("t6_stb_held", 64'(stb), 64'(1));
    rst = 1;
    step();
    rst = 0;
    check("t6_cyc",     64'(cyc), 64'(0));
    check("t6_stb",     64'(stb), 64'(0));
    check("t6_bvalid",  64'(bvalid), 64'(0));
    check("t6_awready", 64'(awready), 64'(1));
    check("t6_wready",  64'(wready), 64'(1));
    stall_left = 0; smode = 0;
    do_write(AW'(32'h504), 32'h88888888, 4'hA);
    wait_b(r);
    check("t6_after_bresp", 64'(r), 64'(2'b00));
    step();

    // Randomized traffic against the model
    smode = 4; rand_axi = 1;
    repeat (3000) step();
    rand_axi = 0; awvalid = 0; wvalid = 0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axilwr2wbsp.md
# axilwr2wbsp

AXI-lite write-channel to Wishbone (pipelined) bridge: accepts independent AW and W beats, joins them into a single Wishbone write, and returns the Wishbone ack/err outcome on the B channel. It sits beside the read-channel bridge; both share the Wishbone master port through the bus arbiter. One write is in flight at a time. A watchdog aborts a hung slave.

## Interface
- C_AXI_DATA_WIDTH, 32: AXI/WB data width DW (8..512, power of 2)
- C_AXI_ADDR_WIDTH, 28: AXI byte-address width; AW = C_AXI_ADDR_WIDTH - log2(DW/8) (word address)
- LGTIMEOUT, 10: watchdog width; abort after 2^LGTIMEOUT-1 cycles in a WB cycle
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_axi_awvalid / o_axi_awready  in/out  1  AW handshake
- i_axi_awaddr  in  AW  word address
- i_axi_awprot  in  3  ignored
- i_axi_wvalid / o_axi_wready  in/out  1  W handshake
- i_axi_wdata  in  DW  write data
- i_axi_wstrb  in  DW/8  byte strobes
- o_axi_bvalid / i_axi_bready  out/in  1  B handshake
- o_axi_bresp  out  2  00 OKAY, 10 SLVERR
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  WB cycle, strobe, write-enable
- o_wb_addr  out  AW  WB word address
- o_wb_data  out  DW  WB write data
- o_wb_sel  out  DW/8  byte selects
- i_wb_stall, i_wb_ack, i_wb_err  in  1  WB slave responses

## Operation
- Buffers: aw_full holds awaddr; w_full holds wdata/wstrb. o_axi_awready = !aw_full, o_axi_wready = !w_full (driven from registers). AW and W accepted independently, in either order.
- States: IDLE, STB, WAIT, RESP.
- IDLE: if aw_full && w_full, then at the next edge: cyc=stb=1; o_wb_addr, o_wb_data, and o_wb_sel load from the buffers; aw_full and w_full clear; go to STB.
- STB: stb held, with addr/data/sel stable, until an edge samples !i_wb_stall. That edge drops stb and moves to WAIT.
- STB or WAIT: an edge sampling cyc && (ack || err) drops cyc and stb, sets bvalid, and moves to RESP. bresp = 10 if err, else 00. If err and ack coincide, err wins. An ack sampled together with the stb acceptance edge finishes the transaction directly.
- Watchdog: a counter clears when cyc rises and increments every cycle cyc is high. On reaching 2^LGTIMEOUT-1 with no ack/err, cyc and stb drop, bvalid=1, bresp=10, and the state moves to RESP. A late ack/err arriving after the abort is ignored (cyc is low).
- RESP: bvalid and bresp are held until an edge samples bready, which clears bvalid and returns to IDLE. No WB cycle starts in RESP. Buffers may refill during RESP.
- o_wb_we = 1 whenever cyc is high. o_wb_sel = captured wstrb; wstrb = 0 is still issued as a WB write.
- Reset, including mid-transaction: cyc, stb, bvalid, aw_full, and w_full clear at the edge. Any in-flight write and its response are discarded; the state returns to IDLE.

## Timing
- Reset values: o_axi_awready=1, o_axi_wready=1, o_axi_bvalid=0, o_axi_bresp=00, o_wb_cyc=0, o_wb_stb=0, o_wb_we=0. o_wb_addr, o_wb_data, and o_wb_sel are don't-care while cyc=0.
- AW and W both handshake at edge k → stb rises at edge k+1, and awready/wready are high again after edge k+1.
- Zero-stall slave acking one cycle after stb: stb falls at k+2, ack is sampled at k+3, and bvalid rises at k+3.
- With bready held high, bvalid falls at k+4. Peak throughput is one write per 4 cycles with continuously valid AW/W.
- At most one AW and one W are buffered beyond the in-flight write. Further beats stall on ready=0.
- bresp changes only on the edge that sets bvalid.

## Test plan
- Single write: AW addr 0x0000010 and W data 0xDEADBEEF, strb 0xF, in the same cycle; slave stall=0, ack next cycle → one WB write with addr 0x10, data 0xDEADBEEF, sel 0xF; bvalid 3 cycles after the handshake; bresp 00.
- W arrives 5 cycles before AW, strb 0x3; slave stall high 4 cycles → stb held 5 cycles with stable addr/data/sel=0x3; exactly one ack and one B response.
- Slave err on a write → bresp 10; the next write (with ack) → bresp 00; no extra WB cycle is issued.
- LGTIMEOUT=4; slave never acks → cyc drops after 15 cycles and bresp=10. An ack injected afterward causes no second bvalid.
- bready held low 10 cycles while two more AW/W pairs arrive → the first pair is buffered (awready/wready go low after it is buffered); no WB cycle occurs until B completes; afterwards the writes issue in order.
- Reset asserted while stb is held under stall → cyc, stb, and bvalid are 0 after the edge and awready=wready=1. A new write after reset completes normally.
